// File: rtl/cop0_unit.sv
// System coprocessor 0: Status/Cause/EPC/Count/Compare, exception entry/return,
// ei/di, mtc0/mfc0 and the Count/Compare timer interrupt.
module cop0_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
  parameter bit          TIMER_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ins_valid,
  input  logic        stall,
  input  logic [31:0] pc,
  input  logic [2:0]  cop0_op,
  input  logic        cop0_rd,
  input  logic        cop0_wr,
  input  logic [4:0]  rd_sel,
  input  logic [31:0] wdata,
  input  logic [5:0]  hw_int,
  output logic [31:0] rdata,
  output logic        exc_req,
  output logic [31:0] exc_target,
  output logic        int_taken
);

  localparam logic [2:0] COP_OP_MV  = 3'd1;
  localparam logic [2:0] COP_OP_SYS = 3'd2;
  localparam logic [2:0] COP_OP_BRK = 3'd3;
  localparam logic [2:0] COP_OP_RET = 3'd4;
  localparam logic [2:0] COP_OP_EN  = 3'd5;
  localparam logic [2:0] COP_OP_DIS = 3'd6;

  localparam logic [4:0] SEL_COUNT   = 5'd9;
  localparam logic [4:0] SEL_COMPARE = 5'd11;
  localparam logic [4:0] SEL_STATUS  = 5'd12;
  localparam logic [4:0] SEL_CAUSE   = 5'd13;
  localparam logic [4:0] SEL_EPC     = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BRK = 5'd9;

  logic        ie_q, ie_d;
  logic        exl_q, exl_d;
  logic [7:0]  im_q, im_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_q, timer_d;

  logic [7:0]  ip;
  logic [31:0] status_rd, cause_rd, reg_rd;
  logic        go, int_pend, take_int, take_exc, take_ret, take_ien, do_mtc0;

  assign ip        = {hw_int[5] | (TIMER_EN & timer_q), hw_int[4:0], ip_sw_q};
  assign status_rd = {16'h0, im_q, 6'h0, exl_q, ie_q};
  assign cause_rd  = {16'h0, ip, 1'b0, exc_code_q, 2'b00};

  // rst_n gates go so a reset cycle never redirects the PC.
  assign go       = ins_valid & ~stall & rst_n;
  assign int_pend = ie_q & ~exl_q & (|(ip & im_q));
  assign take_int = go & int_pend;
  assign take_exc = go & ~int_pend & ((cop0_op == COP_OP_SYS) | (cop0_op == COP_OP_BRK));
  assign take_ret = go & ~int_pend & (cop0_op == COP_OP_RET);
  assign take_ien = go & ~int_pend & ((cop0_op == COP_OP_EN) | (cop0_op == COP_OP_DIS));
  assign do_mtc0  = go & ~int_pend & (cop0_op == COP_OP_MV) & cop0_rd;

  always_comb begin
    reg_rd = 32'h0;
    case (rd_sel)
      SEL_COUNT:   reg_rd = count_q;
      SEL_COMPARE: reg_rd = compare_q;
      SEL_STATUS:  reg_rd = status_rd;
      SEL_CAUSE:   reg_rd = cause_rd;
      SEL_EPC:     reg_rd = epc_q;
      default:     reg_rd = 32'h0;
    endcase
  end

  always_comb begin
    rdata = 32'h0;
    if ((cop0_op == COP_OP_MV) && cop0_wr) begin
      rdata = reg_rd;
    end else if ((cop0_op == COP_OP_EN) || (cop0_op == COP_OP_DIS)) begin
      rdata = status_rd;
    end
  end

  assign exc_req    = take_int | take_exc | take_ret;
  assign exc_target = take_ret ? epc_q : EXC_VECTOR;
  assign int_taken  = take_int;

  always_comb begin
    ie_d       = ie_q;
    exl_d      = exl_q;
    im_d       = im_q;
    exc_code_d = exc_code_q;
    ip_sw_d    = ip_sw_q;
    epc_d      = epc_q;
    count_d    = count_q + 32'd1;
    compare_d  = compare_q;
    timer_d    = timer_q | (count_q == compare_q);

    if (take_int) begin
      epc_d      = pc;
      exc_code_d = EXC_INT;
      exl_d      = 1'b1;
    end else if (take_exc) begin
      epc_d      = pc;
      exc_code_d = (cop0_op == COP_OP_SYS) ? EXC_SYS : EXC_BRK;
      exl_d      = 1'b1;
    end else if (take_ret) begin
      exl_d = 1'b0;
    end else if (take_ien) begin
      ie_d = (cop0_op == COP_OP_EN);
    end else if (do_mtc0) begin
      case (rd_sel)
        SEL_COUNT:   count_d = wdata;
        SEL_COMPARE: begin
          compare_d = wdata;
          timer_d   = 1'b0;
        end
        SEL_STATUS: begin
          ie_d  = wdata[0];
          exl_d = wdata[1];
          im_d  = wdata[15:8];
        end
        SEL_CAUSE:   ip_sw_d = wdata[9:8];
        SEL_EPC:     epc_d = wdata;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ie_q       <= 1'b0;
      exl_q      <= 1'b0;
      im_q       <= 8'h0;
      exc_code_q <= 5'h0;
      ip_sw_q    <= 2'b00;
      epc_q      <= 32'h0;
      count_q    <= 32'h0;
      compare_q  <= 32'h0;
      timer_q    <= 1'b0;
    end else begin
      ie_q       <= ie_d;
      exl_q      <= exl_d;
      im_q       <= im_d;
      exc_code_q <= exc_code_d;
      ip_sw_q    <= ip_sw_d;
      epc_q      <= epc_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      timer_q    <= timer_d;
    end
  end

endmodule

// File: tb/tb_cop0_unit.sv
// Directed bench for cop0_unit: reset, syscall, eret, ei + interrupt, timer, priority.
module tb_cop0_unit;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_MV   = 3'd1;
  localparam logic [2:0] OP_SYS  = 3'd2;
  localparam logic [2:0] OP_BRK  = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_EN   = 3'd5;

  logic        clk, rst_n, ins_valid, stall, cop0_rd, cop0_wr;
  logic [31:0] pc, wdata, rdata, exc_target;
  logic [2:0]  cop0_op;
  logic [4:0]  rd_sel;
  logic [5:0]  hw_int;
  logic        exc_req, int_taken;
  int          passed = 0;
  int          total = 0;

  cop0_unit dut (
    .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .stall(stall), .pc(pc),
    .cop0_op(cop0_op), .cop0_rd(cop0_rd), .cop0_wr(cop0_wr), .rd_sel(rd_sel),
    .wdata(wdata), .hw_int(hw_int), .rdata(rdata), .exc_req(exc_req),
    .exc_target(exc_target), .int_taken(int_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    ins_valid = 1'b0; stall = 1'b0; cop0_op = OP_NONE;
    cop0_rd = 1'b0; cop0_wr = 1'b0; rd_sel = 5'd0; wdata = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] addr);
    idle();
    ins_valid = 1'b1; cop0_op = op; pc = addr;
  endtask

  // Combinational mfc0 read with ins_valid=0 so no state is disturbed.
  task automatic peek(input logic [4:0] sel, output logic [31:0] val);
    idle();
    cop0_op = OP_MV; cop0_wr = 1'b1; rd_sel = sel;
    #1;
    val = rdata;
    idle();
  endtask

  task automatic mtc0(input logic [4:0] sel, input logic [31:0] val);
    idle();
    ins_valid = 1'b1; cop0_op = OP_MV; cop0_rd = 1'b1; rd_sel = sel; wdata = val;
    step();
    idle();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0; hw_int = 6'h0; pc = 32'h0; idle();
    step(); step();
    peek(5'd12, v); total++;
    if (v !== 32'h0) $display("FAIL reset_status got %h want %h", v, 32'h0); else passed++;
    peek(5'd13, v); total++;
    if (v !== 32'h0) $display("FAIL reset_cause got %h want %h", v, 32'h0); else passed++;
    peek(5'd14, v); total++;
    if (v !== 32'h0) $display("FAIL reset_epc got %h want %h", v, 32'h0); else passed++;
    peek(5'd9, v); total++;
    if (v !== 32'h0) $display("FAIL reset_count got %h want %h", v, 32'h0); else passed++;
    drive(OP_SYS, 32'h40);
    #1; total++;
    if (exc_req !== 1'b0) $display("FAIL reset_exc_req got %b want 0", exc_req); else passed++;
    idle();
    rst_n = 1'b1;
    step();  // Count 0 == Compare 0 on the first live edge raises the timer flag
    peek(5'd13, v); total++;
    if (v !== 32'h8000) $display("FAIL reset_timer_flag got %h want %h", v, 32'h8000);
    else passed++;
    mtc0(5'd11, 32'hFFFF_0000);
    peek(5'd13, v); total++;
    if (v !== 32'h0) $display("FAIL compare_clear got %h want %h", v, 32'h0); else passed++;
  endtask

  task automatic test_syscall();
    logic [31:0] v;
    drive(OP_SYS, 32'h40); stall = 1'b1;
    #1; total++;
    if (exc_req !== 1'b0) $display("FAIL sys_stalled got %b want 0", exc_req); else passed++;
    step();
    drive(OP_SYS, 32'h40);
    #1; total++;
    if (exc_req !== 1'b1) $display("FAIL sys_exc_req got %b want 1", exc_req); else passed++;
    total++;
    if (exc_target !== 32'h180) $display("FAIL sys_target got %h want %h", exc_target, 32'h180);
    else passed++;
    step(); idle();
    peek(5'd14, v); total++;
    if (v !== 32'h40) $display("FAIL sys_epc got %h want %h", v, 32'h40); else passed++;
    peek(5'd13, v); total++;
    if (v !== 32'h20) $display("FAIL sys_cause got %h want %h", v, 32'h20); else passed++;
    peek(5'd12, v); total++;
    if (v !== 32'h2) $display("FAIL sys_status got %h want %h", v, 32'h2); else passed++;
  endtask

  task automatic test_eret();
    logic [31:0] v;
    mtc0(5'd14, 32'h44);
    drive(OP_RET, 32'h50);
    #1; total++;
    if (exc_req !== 1'b1) $display("FAIL eret_exc_req got %b want 1", exc_req); else passed++;
    total++;
    if (exc_target !== 32'h44) $display("FAIL eret_target got %h want %h", exc_target, 32'h44);
    else passed++;
    step(); idle();
    peek(5'd12, v); total++;
    if (v !== 32'h0) $display("FAIL eret_status got %h want %h", v, 32'h0); else passed++;
  endtask

  task automatic test_ei_interrupt();
    logic [31:0] v;
    mtc0(5'd12, 32'h0400);
    drive(OP_EN, 32'h60); cop0_wr = 1'b1;
    #1; total++;
    if (rdata !== 32'h0400) $display("FAIL ei_rdata got %h want %h", rdata, 32'h0400);
    else passed++;
    step(); idle();
    peek(5'd12, v); total++;
    if (v !== 32'h0401) $display("FAIL ei_status got %h want %h", v, 32'h0401); else passed++;
    hw_int = 6'b000001;
    drive(OP_NONE, 32'h100); stall = 1'b1;
    #1; total++;
    if (int_taken !== 1'b0) $display("FAIL int_stalled got %b want 0", int_taken); else passed++;
    step(); idle();
    peek(5'd12, v); total++;
    if (v !== 32'h0401) $display("FAIL int_stall_status got %h want %h", v, 32'h0401);
    else passed++;
    // mtc0 EPC in the interrupted slot must be dropped.
    drive(OP_MV, 32'h100); cop0_rd = 1'b1; rd_sel = 5'd14; wdata = 32'hDEAD;
    #1; total++;
    if (int_taken !== 1'b1) $display("FAIL int_taken got %b want 1", int_taken); else passed++;
    total++;
    if (exc_target !== 32'h180) $display("FAIL int_target got %h want %h", exc_target, 32'h180);
    else passed++;
    step(); idle();
    peek(5'd14, v); total++;
    if (v !== 32'h100) $display("FAIL int_epc got %h want %h", v, 32'h100); else passed++;
    peek(5'd13, v); total++;
    if (v !== 32'h0400) $display("FAIL int_cause got %h want %h", v, 32'h0400); else passed++;
    peek(5'd12, v); total++;
    if (v !== 32'h0403) $display("FAIL int_status got %h want %h", v, 32'h0403); else passed++;
    drive(OP_RET, 32'h104);
    #1; total++;
    if (int_taken !== 1'b0) $display("FAIL ret_blocks_int got %b want 0", int_taken);
    else passed++;
    total++;
    if (exc_target !== 32'h100) $display("FAIL ret_target got %h want %h", exc_target, 32'h100);
    else passed++;
    step();
    drive(OP_NONE, 32'h108);
    #1; total++;
    if (int_taken !== 1'b1) $display("FAIL int_after_ret got %b want 1", int_taken); else passed++;
    step(); idle(); hw_int = 6'h0;
    peek(5'd14, v); total++;
    if (v !== 32'h108) $display("FAIL int_after_ret_epc got %h want %h", v, 32'h108);
    else passed++;
  endtask

  task automatic test_timer();
    logic [31:0] v;
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    mtc0(5'd12, 32'h8001);
    peek(5'd9, v); total++;
    if (v !== 32'd1) $display("FAIL timer_count_start got %h want %h", v, 32'd1); else passed++;
    step(); step(); step(); step();
    peek(5'd9, v); total++;
    if (v !== 32'd5) $display("FAIL timer_count5 got %h want %h", v, 32'd5); else passed++;
    peek(5'd13, v); total++;
    if (v !== 32'h0) $display("FAIL timer_not_yet got %h want %h", v, 32'h0); else passed++;
    step();
    peek(5'd13, v); total++;
    if (v !== 32'h8000) $display("FAIL timer_ip7 got %h want %h", v, 32'h8000); else passed++;
    drive(OP_NONE, 32'h200);
    #1; total++;
    if (int_taken !== 1'b1) $display("FAIL timer_int got %b want 1", int_taken); else passed++;
    step(); idle();
    mtc0(5'd11, 32'h100);
    peek(5'd13, v); total++;
    if (v !== 32'h0) $display("FAIL timer_clear got %h want %h", v, 32'h0); else passed++;
    mtc0(5'd9, 32'hFFFF_FFFF);
    peek(5'd9, v); total++;
    if (v !== 32'hFFFF_FFFF) $display("FAIL count_max got %h want %h", v, 32'hFFFF_FFFF);
    else passed++;
    step();
    peek(5'd9, v); total++;
    if (v !== 32'h0) $display("FAIL count_wrap got %h want %h", v, 32'h0); else passed++;
  endtask

  task automatic test_int_vs_break();
    logic [31:0] v;
    mtc0(5'd12, 32'h0801);
    hw_int = 6'b000010;
    drive(OP_BRK, 32'h300);
    #1; total++;
    if (int_taken !== 1'b1) $display("FAIL brk_int_wins got %b want 1", int_taken); else passed++;
    total++;
    if (exc_req !== 1'b1) $display("FAIL brk_int_exc_req got %b want 1", exc_req); else passed++;
    step(); idle(); hw_int = 6'h0;
    peek(5'd14, v); total++;
    if (v !== 32'h300) $display("FAIL brk_int_epc got %h want %h", v, 32'h300); else passed++;
    peek(5'd13, v); total++;
    if (v !== 32'h0) $display("FAIL brk_int_cause got %h want %h", v, 32'h0); else passed++;
    drive(OP_BRK, 32'h304);
    #1; total++;
    if (exc_req !== 1'b1 || int_taken !== 1'b0)
      $display("FAIL brk_alone got exc_req=%b int=%b want 1/0", exc_req, int_taken);
    else passed++;
    step(); idle();
    peek(5'd13, v); total++;
    if (v !== 32'h24) $display("FAIL brk_cause got %h want %h", v, 32'h24); else passed++;
    peek(5'd14, v); total++;
    if (v !== 32'h304) $display("FAIL brk_epc got %h want %h", v, 32'h304); else passed++;
  endtask

  initial begin
    test_reset();
    test_syscall();
    test_eret();
    test_ei_interrupt();
    test_timer();
    test_int_vs_break();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
